cluster_clock_div_en: RTL
=========================

// Module: cluster_clock_div_en
// PURPOSE
//  Multi-channel programmable clock divider for cluster clock generation. Produces
//  per-channel clock-enable strobes and divided square waves from one root clock.
//  Ratios change glitch-free on period boundaries through a valid/ready handshake.
//  Clocks are never gated: FPGA and ASIC flows consume clk_en_o on the root clock;
//  clk_div_o serves observation and legacy clock ports.
// PARAMETERS
//  NUM_CH   4  number of independent divider channels
//  DIV_W    8  width of each divide ratio; ratio range 1..2**DIV_W-1
//  DIV_RST  1  divide ratio loaded into every channel at reset
// PORTS
//  clk_i        in   1             root clock; all logic on rising edge
//  rst_ni       in   1             synchronous reset, active low
//  test_mode_i  in   1             DFT bypass: clk_en_o forced 1, clk_div_o forced 0
//  en_i         in   NUM_CH        per-channel run request, level
//  div_i        in   NUM_CH*DIV_W  new ratio; channel c in [c*DIV_W +: DIV_W]
//  div_valid_i  in   NUM_CH        ratio update request
//  div_ready_o  out  NUM_CH        ratio accepted when valid & ready
//  clk_en_o     out  NUM_CH        one strobe per divided period
//  clk_div_o    out  NUM_CH        divided square wave
//  busy_o       out  NUM_CH        channel not IDLE
// BEHAVIOUR
//  Per-channel state: FSM {IDLE,RUN,STOP}, cnt_q[DIV_W], div_q[DIV_W].
//   Effective ratio D = (div_q==0) ? 1 : div_q.
//  Reset, at the clk_i edge with rst_ni=0, all channels:
//   - state=IDLE, cnt_q=0, div_q=DIV_RST.
//   - Hence clk_en_o=0, clk_div_o=0, busy_o=0, div_ready_o=1.
//   - Reset mid-period aborts immediately; no drain.
//  Outputs decode registers only; no input-to-output comb path except test_mode_i:
//   clk_en_o  = state!=IDLE && cnt_q==D-1
//   clk_div_o = state!=IDLE && cnt_q < (D+1)/2  (D odd: high one extra cycle)
//   busy_o    = state!=IDLE
//   div_ready_o = state==IDLE || cnt_q==D-1  (period boundary)
//  Counter: in RUN/STOP, cnt_q wraps D-1 -> 0, else increments. In IDLE, held at 0.
//  FSM transitions:
//   - IDLE -> RUN: en_i=1; cnt_q=0.
//   - RUN -> STOP: en_i=0; current period completes.
//   - STOP -> RUN: en_i=1 again; seamless, cnt continues.
//   - STOP -> IDLE: at cnt_q==D-1 with en_i=0. Final strobe is still emitted.
//  Timing: en_i sampled 1 at edge E0 (IDLE). First clk_en_o in cycle E0+D-1
//   (D cycles after E0, counting E0's cycle). Then one strobe every D cycles.
//  Ratio update: on div_valid_i & div_ready_o, div_q<=div_i slice and cnt_q<=0.
//   - New D governs the next period; no runt or stretched strobe.
//   - Valid must hold until ready. Ready may drop without transfer mid-period.
//   - Simultaneous update and STOP->IDLE: both take effect (div_q loaded, IDLE).
//  test_mode_i=1: outputs forced as listed; FSM, counters and handshake run normally.
//  Channels fully independent; no shared state.
// TESTING
//  1. Reset: rst_ni=0 for 2 edges with en_i=all 1.
//     -> clk_en_o=0, clk_div_o=0, busy_o=0, div_ready_o=1.
//  2. ch0 div=4, en_i[0]=1 at E0.
//     -> clk_en_o[0] at E0+3, E0+7, E0+11.
//     -> clk_div_o[0] = 1100 repeating.
//  3. ch1 running D=3; present div=5 mid-period.
//     -> Accepted only at the cnt=2 cycle; next strobes 5 apart; no short period.
//  4. ch2 D=6, en_i drops at cnt=1.
//     -> Strobe at cnt=5, then IDLE, busy_o=0.
//     -> Re-enable at cnt=3 of that period instead: no gap, busy stays 1.
//  5. div=0 and div=1 -> clk_en_o and clk_div_o constant 1 while enabled.
//     test_mode_i=1 -> clk_en_o=1, clk_div_o=0 on all channels.
//  6. rst_ni=0 mid-period on all channels.
//     -> Next cycle all IDLE, div_q=DIV_RST. Other channels unaffected by per-channel traffic.

Source files
------------

// File: rtl/cluster_clock_div_en.sv
// Multi-channel programmable clock divider producing per-channel enable strobes and
// divided square waves from the root clock; ratio updates only on period boundaries.
module cluster_clock_div_en #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DIV_RST = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       div_valid_i,
  output logic [NUM_CH-1:0]       div_ready_o,
  output logic [NUM_CH-1:0]       clk_en_o,
  output logic [NUM_CH-1:0]       clk_div_o,
  output logic [NUM_CH-1:0]       busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [DIV_W-1:0] cnt_q   [NUM_CH];
  logic [DIV_W-1:0] cnt_d   [NUM_CH];
  logic [DIV_W-1:0] div_q   [NUM_CH];
  logic [DIV_W-1:0] div_d   [NUM_CH];
  logic [DIV_W-1:0] dmax    [NUM_CH];
  logic [NUM_CH-1:0] wrap;
  logic [NUM_CH-1:0] ready;

  // dmax is D-1 with div_q==0 treated as D=1
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      dmax[c]  = (div_q[c] == '0) ? '0 : div_q[c] - ONE;
      wrap[c]  = (cnt_q[c] == dmax[c]);
      ready[c] = (state_q[c] == IDLE) || wrap[c];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (!rst_ni) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        div_q[c]   <= DIV_W'(DIV_RST);
      end else begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        div_q[c]   <= div_d[c];
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      div_d[c]   = div_q[c];
      unique case (state_q[c])
        IDLE:     if (en_i[c]) state_d[c] = RUN;
        RUN,
        STOP: begin
          if (en_i[c])     state_d[c] = RUN;
          else if (wrap[c]) state_d[c] = IDLE;
          else             state_d[c] = STOP;
        end
        default:  state_d[c] = IDLE;
      endcase
      if (state_q[c] == IDLE || wrap[c]) cnt_d[c] = '0;
      else                               cnt_d[c] = cnt_q[c] + ONE;
      if (div_valid_i[c] && ready[c]) begin
        div_d[c] = div_i[c*DIV_W +: DIV_W];
        cnt_d[c] = '0;
      end
    end
  end

  // cnt < (D+1)/2 is equivalent to cnt <= (D-1)/2 for both odd and even D
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      busy_o[c]      = (state_q[c] != IDLE);
      div_ready_o[c] = ready[c];
      clk_en_o[c]    = test_mode_i | (busy_o[c] & wrap[c]);
      clk_div_o[c]   = ~test_mode_i & busy_o[c] & (cnt_q[c] <= (dmax[c] >> 1));
    end
  end

endmodule
